path_traceback: RTL and testbench
=================================

PATH_TRACEBACK -- requirements
Module: path_traceback

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-002 SHALL have port Rst, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port Go, input, 1, start request, sampled only in IDLE.
REQ-004 SHALL have ports P_In and L_In, input, 8 each, read data from the direction memory P and the cost memory L.
REQ-005 SHALL have ports P_Addr, L_Addr and R_Addr, output reg, 13 each, SRAM addresses.
REQ-006 SHALL have ports P_En/P_Rw, L_En/L_Rw and R_En/R_Rw, output reg, 1 each, where Rw=1 means write.
REQ-007 SHALL have port R_Out, output reg, 8, write data to the result memory R.
REQ-008 SHALL have port Done, output reg, 1, a one-cycle completion pulse.
REQ-009 SHALL have port Err, output reg, 1, a sticky malformed-path flag, cleared by an accepted Go.

Function
REQ-010 SHALL process NUM_TILES tiles of SIZE_ROW x SIZE_ROW cells; the base address of tile T is T*16, and cell (i,j) is at base + i*4 + j.
REQ-011 SHALL treat direction codes as Start=0x08, Right=0x09, Down=0x0A; Right SHALL step to (i,j-1) and Down SHALL step to (i-1,j).
REQ-012 SHALL drive every memory-control output and R_Out to 0 in any cycle where the state does not assert them.
REQ-013 SHALL keep each En high for exactly one cycle per access.
REQ-014 SHALL use issue/wait/capture for every read: En high in cycle n, no action in n+1, data captured on In at the edge ending n+2.
REQ-015 SHALL implement states IDLE, COST_RD, COST_WT, COST_CAP, P_RD, P_WT, P_CAP, STEP, LEN_WR, NEXT, FIN.
REQ-016 SHALL go IDLE->COST_RD on Go=1, clearing Err, tile=0 and step=0.
REQ-017 SHALL ignore Go in every state other than IDLE.
REQ-018 SHALL read L at base+15 in COST_RD, then write the captured cost to R[base+1] in COST_CAP, then set (i,j)=(3,3).
REQ-019 SHALL read P at the cell in P_RD; in P_CAP it SHALL write the cell index {4'b0,i,j} to R[base+2+step] and increment step.
REQ-020 SHALL, in STEP, go to LEN_WR on Start, apply the move and return to P_RD on Right or Down, and flag an error otherwise.
REQ-021 SHALL flag an error on any code other than 0x08/0x09/0x0A, on Right with j=0, on Down with i=0, or when step reaches 7 without a Start code.
REQ-022 SHALL, on an error, set Err=1 and go to LEN_WR with length 0xFF.
REQ-023 SHALL, in LEN_WR, write step (or 0xFF) to R[base+0], then go to NEXT.
REQ-024 SHALL, in NEXT, increment tile and go to COST_RD, or go to FIN if tile = NUM_TILES-1.
REQ-025 SHALL, in FIN, assert Done=1 for one cycle and return to IDLE; Err SHALL hold its value.
REQ-026 SHALL form addresses as a 13-bit concatenation of tile[8:0] and a 4-bit offset, with no overflow possible.
REQ-027 SHALL never write P or L; P_Rw and L_Rw SHALL remain 0.

Reset
REQ-028 SHALL, while Rst=0, immediately force all outputs, registers, tile, step and (i,j) to 0 and the state to IDLE, independent of Clk.
REQ-029 SHALL abandon any access in flight when reset is asserted mid-run, SHALL NOT pulse Done, and SHALL restart a following Go from tile 0.

Structure
REQ-030 SHALL take SIZE_ROW=4, D_WIDTH=8, A_WIDTH=13, NUM_TILES=512, the direction codes and the state encodings from shared package sp_pkg.
REQ-031 SHALL expose NUM_TILES as an overridable parameter so benches can use small values.
REQ-032 SHALL be a single flat FSM module with no sub-modules, because the datapath is only an index counter.

Verification
REQ-033 SHALL cover this scenario: NUM_TILES=1, P[3]=9, P[2]=9, P[1]=9, P[0]=8, P[7]=P[11]=P[15]=0x0A, L[15]=0x2A -> R[0]=7, R[1]=0x2A, R[2..8]=15,11,7,3,2,1,0, Done pulses once, Err=0.
REQ-034 SHALL cover this scenario: P[15]=0x00 -> R[0]=0xFF, R[2]=15, Err=1, Done pulses once.
REQ-035 SHALL cover this scenario: P[15]=P[14]=P[13]=P[12]=0x09 -> Right at j=0 is detected, R[0]=0xFF, Err=1.
REQ-036 SHALL cover this scenario: NUM_TILES=2 with tile 1 all-Start at cell 15 -> R[16]=1, R[18]=15, Done only after tile 1, Go pulsed mid-run has no effect.
REQ-037 SHALL cover this scenario: Rst driven low between clock edges during P_WT -> all outputs 0 at once, no Done, and a re-issued Go reproduces the REQ-033 results.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared constants, direction codes and FSM encoding for the path traceback engine.
// Tile geometry is fixed at 4x4 cells; addresses are {tile, 4-bit cell offset}.
package sp_pkg;

    localparam int SIZE_ROW  = 4;
    localparam int D_WIDTH   = 8;
    localparam int A_WIDTH   = 13;
    localparam int NUM_TILES = 512;
    localparam int TILE_W    = 9;
    localparam int OFS_W     = 4;
    localparam int STEP_W    = 3;

    localparam logic [D_WIDTH-1:0] DIR_START = 8'h08;
    localparam logic [D_WIDTH-1:0] DIR_RIGHT = 8'h09;
    localparam logic [D_WIDTH-1:0] DIR_DOWN  = 8'h0A;
    localparam logic [D_WIDTH-1:0] LEN_ERR   = 8'hFF;

    // A 4x4 walk from (3,3) to (0,0) visits at most 7 cells.
    localparam logic [STEP_W-1:0] MAX_STEP = 3'd7;

    // Result layout inside a tile: length, cost, then the visited cell list.
    localparam logic [OFS_W-1:0] OFS_LEN  = 4'd0;
    localparam logic [OFS_W-1:0] OFS_COST = 4'd1;
    localparam logic [OFS_W-1:0] OFS_PATH = 4'd2;
    localparam logic [OFS_W-1:0] OFS_LAST = 4'd15;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        COST_RD  = 4'd1,
        COST_WT  = 4'd2,
        COST_CAP = 4'd3,
        P_RD     = 4'd4,
        P_WT     = 4'd5,
        P_CAP    = 4'd6,
        STEP     = 4'd7,
        LEN_WR   = 4'd8,
        NEXT     = 4'd9,
        FIN      = 4'd10
    } state_t;

    function automatic logic [A_WIDTH-1:0] mk_addr(input logic [TILE_W-1:0] tile,
                                                   input logic [OFS_W-1:0]  ofs);
        return {tile, ofs};
    endfunction

endpackage

// File: rtl/path_traceback.sv
// Walks each 4x4 tile's direction map from (3,3) back to Start, writing cost, path and length to R.
// Latency: reads take 3 cycles (issue/wait/capture); ~4 cycles per visited cell plus 6 per tile.
// No backpressure: all three SRAMs are fixed-latency and always ready.
module path_traceback #(
    parameter int NUM_TILES = sp_pkg::NUM_TILES
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Go,
    input  logic [sp_pkg::D_WIDTH-1:0] P_In,
    input  logic [sp_pkg::D_WIDTH-1:0] L_In,
    output logic [sp_pkg::A_WIDTH-1:0] P_Addr,
    output logic [sp_pkg::A_WIDTH-1:0] L_Addr,
    output logic [sp_pkg::A_WIDTH-1:0] R_Addr,
    output logic                       P_En,
    output logic                       P_Rw,
    output logic                       L_En,
    output logic                       L_Rw,
    output logic                       R_En,
    output logic                       R_Rw,
    output logic [sp_pkg::D_WIDTH-1:0] R_Out,
    output logic                       Done,
    output logic                       Err
);

    import sp_pkg::state_t;
    import sp_pkg::IDLE;
    import sp_pkg::COST_RD;
    import sp_pkg::COST_WT;
    import sp_pkg::COST_CAP;
    import sp_pkg::P_RD;
    import sp_pkg::P_WT;
    import sp_pkg::P_CAP;
    import sp_pkg::STEP;
    import sp_pkg::LEN_WR;
    import sp_pkg::NEXT;
    import sp_pkg::FIN;
    import sp_pkg::TILE_W;
    import sp_pkg::STEP_W;
    import sp_pkg::D_WIDTH;
    import sp_pkg::DIR_START;
    import sp_pkg::DIR_RIGHT;
    import sp_pkg::DIR_DOWN;
    import sp_pkg::LEN_ERR;
    import sp_pkg::MAX_STEP;
    import sp_pkg::OFS_LEN;
    import sp_pkg::OFS_COST;
    import sp_pkg::OFS_PATH;
    import sp_pkg::OFS_LAST;
    import sp_pkg::mk_addr;

    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

    state_t              state;
    logic [TILE_W-1:0]   tile;
    logic [STEP_W-1:0]   step;
    logic [1:0]          ci;
    logic [1:0]          cj;
    logic [D_WIDTH-1:0]  p_code;

    logic [1:0]          mv_i;
    logic [1:0]          mv_j;
    logic                at_start;
    logic                bad;

    // Decode the captured direction against the current cell and walk length.
    always_comb begin
        mv_i     = ci;
        mv_j     = cj;
        at_start = 1'b0;
        bad      = 1'b0;
        case (p_code)
            DIR_START: at_start = 1'b1;
            DIR_RIGHT: if (cj == 2'd0) bad = 1'b1; else mv_j = cj - 2'd1;
            DIR_DOWN:  if (ci == 2'd0) bad = 1'b1; else mv_i = ci - 2'd1;
            default:   bad = 1'b1;
        endcase
        if (step == MAX_STEP && !at_start) bad = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            tile   <= '0;
            step   <= '0;
            ci     <= '0;
            cj     <= '0;
            p_code <= '0;
            P_Addr <= '0;
            L_Addr <= '0;
            R_Addr <= '0;
            P_En   <= 1'b0;
            P_Rw   <= 1'b0;
            L_En   <= 1'b0;
            L_Rw   <= 1'b0;
            R_En   <= 1'b0;
            R_Rw   <= 1'b0;
            R_Out  <= '0;
            Done   <= 1'b0;
            Err    <= 1'b0;
        end else begin
            P_Addr <= '0;
            L_Addr <= '0;
            R_Addr <= '0;
            P_En   <= 1'b0;
            P_Rw   <= 1'b0;
            L_En   <= 1'b0;
            L_Rw   <= 1'b0;
            R_En   <= 1'b0;
            R_Rw   <= 1'b0;
            R_Out  <= '0;
            Done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (Go) begin
                        Err    <= 1'b0;
                        tile   <= '0;
                        step   <= '0;
                        L_En   <= 1'b1;
                        L_Addr <= mk_addr('0, OFS_LAST);
                        state  <= COST_RD;
                    end
                end
                COST_RD: state <= COST_WT;
                COST_WT: state <= COST_CAP;
                COST_CAP: begin
                    R_En   <= 1'b1;
                    R_Rw   <= 1'b1;
                    R_Addr <= mk_addr(tile, OFS_COST);
                    R_Out  <= L_In;
                    ci     <= 2'd3;
                    cj     <= 2'd3;
                    P_En   <= 1'b1;
                    P_Addr <= mk_addr(tile, {2'd3, 2'd3});
                    state  <= P_RD;
                end
                P_RD: state <= P_WT;
                P_WT: state <= P_CAP;
                P_CAP: begin
                    p_code <= P_In;
                    R_En   <= 1'b1;
                    R_Rw   <= 1'b1;
                    R_Addr <= mk_addr(tile, OFS_PATH + {1'b0, step});
                    R_Out  <= {4'b0, ci, cj};
                    step   <= step + 3'd1;
                    state  <= STEP;
                end
                STEP: begin
                    if (bad || at_start) begin
                        if (bad) Err <= 1'b1;
                        R_En   <= 1'b1;
                        R_Rw   <= 1'b1;
                        R_Addr <= mk_addr(tile, OFS_LEN);
                        R_Out  <= bad ? LEN_ERR : {5'd0, step};
                        state  <= LEN_WR;
                    end else begin
                        ci     <= mv_i;
                        cj     <= mv_j;
                        P_En   <= 1'b1;
                        P_Addr <= mk_addr(tile, {mv_i, mv_j});
                        state  <= P_RD;
                    end
                end
                LEN_WR: state <= NEXT;
                NEXT: begin
                    if (tile == LAST_TILE) begin
                        Done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        tile   <= tile + 9'd1;
                        step   <= '0;
                        L_En   <= 1'b1;
                        L_Addr <= mk_addr(tile + 9'd1, OFS_LAST);
                        state  <= COST_RD;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_traceback.sv
// Bench for path_traceback: a 1-tile and a 2-tile instance, each with its own P/L SRAM model.
module tb_path_traceback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go     [2];
    logic [7:0]  p_rd   [2];
    logic [7:0]  l_rd   [2];
    logic [12:0] p_addr [2];
    logic [12:0] l_addr [2];
    logic [12:0] r_addr [2];
    logic        p_en   [2];
    logic        p_rw   [2];
    logic        l_en   [2];
    logic        l_rw   [2];
    logic        r_en   [2];
    logic        r_rw   [2];
    logic [7:0]  r_out  [2];
    logic        done   [2];
    logic        err    [2];
    logic [7:0]  pmem   [2][32];
    logic [7:0]  lmem   [2][32];

    typedef struct packed {
        logic [15:0][7:0] p;
        logic [7:0]       l15;
        logic [6:0][7:0]  path;
        logic [3:0]       npath;
        logic [7:0]       len;
        logic             bad;
    } vec_t;

    typedef struct packed {
        logic        k;
        logic [12:0] addr;
        logic [7:0]  dat;
    } wr_t;

    wr_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt [2];
    vec_t tbl [6];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        path_traceback #(.NUM_TILES(k + 1)) u_dut (
            .Clk    (clk),
            .Rst    (rst_n),
            .Go     (go[k]),
            .P_In   (p_rd[k]),
            .L_In   (l_rd[k]),
            .P_Addr (p_addr[k]),
            .L_Addr (l_addr[k]),
            .R_Addr (r_addr[k]),
            .P_En   (p_en[k]),
            .P_Rw   (p_rw[k]),
            .L_En   (l_en[k]),
            .L_Rw   (l_rw[k]),
            .R_En   (r_en[k]),
            .R_Rw   (r_rw[k]),
            .R_Out  (r_out[k]),
            .Done   (done[k]),
            .Err    (err[k])
        );
    end

    // Synchronous-read SRAMs: data appears after the edge that samples En and holds until the next read.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (p_en[k] && !p_rw[k]) p_rd[k] <= pmem[k][p_addr[k][4:0]];
            if (l_en[k] && !l_rw[k]) l_rd[k] <= lmem[k][l_addr[k][4:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs(input int k);
        return {9'd0, p_en[k], p_rw[k], l_en[k], l_rw[k], r_en[k], r_rw[k], done[k], err[k],
                p_addr[k], l_addr[k], r_addr[k], r_out[k]};
    endfunction

    // One clock; every R write is matched against the scoreboard as it happens.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("p_l_readonly", {62'd0, p_rw[k], l_rw[k]}, 64'd0);
            if (r_en[k]) begin
                if (exp_q.size() == 0) begin
                    chk("r_write_unexpected", {51'd0, r_addr[k]}, 64'h1FFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("r_write_inst", 64'(k), 64'(e.k));
                    chk("r_write_rw", 64'(r_rw[k]), 64'd1);
                    chk("r_write_addr", 64'(r_addr[k]), 64'(e.addr));
                    chk("r_write_data", 64'(r_out[k]), 64'(e.dat));
                end
            end else begin
                chk("r_idle_zero", {42'd0, r_rw[k], r_addr[k], r_out[k]}, 64'd0);
            end
            if (done[k]) begin
                done_cnt[k]++;
                chk("done_after_writes", 64'(exp_q.size()), 64'd0);
            end
        end
    endtask

    task automatic load_tile(input int k, input int t, input vec_t v);
        for (int c = 0; c < 16; c++) pmem[k][t*16 + c] = v.p[c];
        lmem[k][t*16 + 15] = v.l15;
    endtask

    task automatic push_tile(input int k, input int t, input vec_t v);
        wr_t         e;
        logic [12:0] base;
        base = 13'(t * 16);
        e.k = 1'(k);
        e.addr = base + 13'd1; e.dat = v.l15; exp_q.push_back(e);
        for (int s = 0; s < int'(v.npath); s++) begin
            e.addr = base + 13'd2 + 13'(s);
            e.dat  = v.path[s];
            exp_q.push_back(e);
        end
        e.addr = base; e.dat = v.len; exp_q.push_back(e);
    endtask

    task automatic run(input int k, input vec_t v0, input vec_t v1, input int ntile,
                       input bit mid_go, input string name);
        done_cnt[k] = 0;
        load_tile(k, 0, v0);
        push_tile(k, 0, v0);
        if (ntile > 1) begin
            load_tile(k, 1, v1);
            push_tile(k, 1, v1);
        end
        go[k] = 1'b1;
        tick();
        go[k] = 1'b0;
        for (int c = 0; c < 400 && done_cnt[k] == 0; c++) begin
            if (mid_go && c == 12) go[k] = 1'b1;
            tick();
            go[k] = 1'b0;
        end
        for (int c = 0; c < 6; c++) tick();
        chk({name, "_done_once"}, 64'(done_cnt[k]), 64'd1);
        chk({name, "_err"}, 64'(err[k]), 64'(v0.bad | (ntile > 1 && v1.bad)));
        chk({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        go[0] = 1'b0;
        go[1] = 1'b0;
        rst_n = 1'b0;

        for (int i = 0; i < 6; i++) begin
            tbl[i]   = '0;
            tbl[i].p = {16{8'hEE}};
        end
        // Down x3 then Right x3 to Start: 7 cells.
        tbl[0].p[15] = 8'h0A; tbl[0].p[11] = 8'h0A; tbl[0].p[7] = 8'h0A;
        tbl[0].p[3]  = 8'h09; tbl[0].p[2]  = 8'h09; tbl[0].p[1] = 8'h09; tbl[0].p[0] = 8'h08;
        tbl[0].l15 = 8'h2A; tbl[0].npath = 4'd7; tbl[0].len = 8'd7; tbl[0].bad = 1'b0;
        tbl[0].path[0] = 8'd15; tbl[0].path[1] = 8'd11; tbl[0].path[2] = 8'd7;
        tbl[0].path[3] = 8'd3;  tbl[0].path[4] = 8'd2;  tbl[0].path[5] = 8'd1; tbl[0].path[6] = 8'd0;
        // Illegal code at the first cell.
        tbl[1].p[15] = 8'h00; tbl[1].l15 = 8'h11;
        tbl[1].path[0] = 8'd15; tbl[1].npath = 4'd1; tbl[1].len = 8'hFF; tbl[1].bad = 1'b1;
        // Right off the j=0 edge.
        tbl[2].p[15] = 8'h09; tbl[2].p[14] = 8'h09; tbl[2].p[13] = 8'h09; tbl[2].p[12] = 8'h09;
        tbl[2].l15 = 8'h33; tbl[2].npath = 4'd4; tbl[2].len = 8'hFF; tbl[2].bad = 1'b1;
        tbl[2].path[0] = 8'd15; tbl[2].path[1] = 8'd14; tbl[2].path[2] = 8'd13; tbl[2].path[3] = 8'd12;
        // Down off the i=0 edge.
        tbl[3].p[15] = 8'h0A; tbl[3].p[11] = 8'h0A; tbl[3].p[7] = 8'h0A; tbl[3].p[3] = 8'h0A;
        tbl[3].l15 = 8'h44; tbl[3].npath = 4'd4; tbl[3].len = 8'hFF; tbl[3].bad = 1'b1;
        tbl[3].path[0] = 8'd15; tbl[3].path[1] = 8'd11; tbl[3].path[2] = 8'd7; tbl[3].path[3] = 8'd3;
        // Start immediately at (3,3).
        tbl[4].p[15] = 8'h08; tbl[4].l15 = 8'h55;
        tbl[4].path[0] = 8'd15; tbl[4].npath = 4'd1; tbl[4].len = 8'd1; tbl[4].bad = 1'b0;
        // Every cell is Start.
        tbl[5].p = {16{8'h08}}; tbl[5].l15 = 8'h5C;
        tbl[5].path[0] = 8'd15; tbl[5].npath = 4'd1; tbl[5].len = 8'd1; tbl[5].bad = 1'b0;

        tick();
        tick();
        for (int k = 0; k < 2; k++) chk("reset_outputs", outs(k), 64'd0);
        rst_n = 1'b1;
        tick();

        // Error vectors are interleaved with clean ones so Go must clear Err.
        for (int i = 0; i < 5; i++) run(0, tbl[i], tbl[i], 1, 1'b0, $sformatf("vec%0d", i));

        // Two tiles, with a stray Go while busy.
        run(1, tbl[0], tbl[5], 2, 1'b1, "two_tile");

        // Reset asserted between edges while the first P read is in its wait cycle.
        done_cnt[0] = 0;
        load_tile(0, 0, tbl[0]);
        push_tile(0, 0, tbl[0]);
        go[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", outs(0), 64'd0);
        exp_q.delete();
        tick();
        tick();
        chk("rst_hold_outputs", outs(0), 64'd0);
        chk("rst_no_done", 64'(done_cnt[0]), 64'd0);
        rst_n = 1'b1;
        tick();
        run(0, tbl[0], tbl[0], 1, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
